// File: rtl/axi4lite_pkg.sv
// Shared definitions for the two-requester AXI4-Lite master arbiter.
package axi4lite_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

endpackage

// File: rtl/axi4lite_rr_grant.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module axi4lite_rr_grant
    import axi4lite_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               last_grant,
    output logic               grant,
    output logic               grant_valid
);

    always_comb begin
        grant_valid = |req_valid;
        grant       = req_valid[1];
        if (req_valid == 2'b11) begin
            grant = ~last_grant;
        end
    end

endmodule

// File: rtl/axi4lite_arbiter.sv
// Shares one AXI4-Lite master port between two one-beat command sources, round-robin,
// and returns a single-cycle completion pulse to the owning requester.
module axi4lite_arbiter
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [DATA_WIDTH-1:0]         m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]       m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    rready_q, rready_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;

    logic                    grant;
    logic                    grant_valid;
    logic                    accept;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    axi4lite_rr_grant u_rr_grant (
        .req_valid   (req_valid),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign accept    = (state_q == ST_IDLE) && grant_valid;
    assign req_ready = {accept & grant, accept & ~grant};

    assign sel_write = grant ? req_write[1] : req_write[0];
    assign sel_addr  = grant ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
    assign sel_wdata = grant ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        awaddr_d     = awaddr_q;
        araddr_d     = araddr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        bready_d     = bready_q;
        rready_d     = rready_q;
        rsp_valid_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    last_grant_d = grant;
                    owner_d      = grant;
                    if (sel_write) begin
                        awaddr_d  = sel_addr;
                        wdata_d   = sel_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        araddr_d  = sel_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                // AW and W retire independently; a channel already done stays low.
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (m_axi_bvalid) begin
                    resp_d      = m_axi_bresp;
                    rdata_d     = '0;
                    bready_d    = 1'b0;
                    rsp_valid_d = {owner_q, ~owner_q};
                    state_d     = ST_RESP;
                end
            end
            ST_READ: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (m_axi_rvalid) begin
                    rdata_d     = m_axi_rdata;
                    resp_d      = m_axi_rresp;
                    rready_d    = 1'b0;
                    rsp_valid_d = {owner_q, ~owner_q};
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_q       <= OKAY;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            rready_q     <= 1'b0;
            rsp_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            bready_q     <= bready_d;
            rready_q     <= rready_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: doc/axi4lite_arbiter.md
# axi4lite_arbiter

Two-requester AXI4-Lite master controller that shares the single AXI4-Lite slave port between two independent command sources. Each requester issues one-beat read or write commands over a simple valid/ready request channel. The block grants requesters round-robin, runs the full AXI4-Lite handshake sequence for the granted command, and returns a one-cycle response pulse to the owner. It sits between the top-level command decode and the existing AXI4-Lite slave, in place of a single dedicated master.

## Interface
- ADDR_WIDTH, 2, AXI address width
- DATA_WIDTH, 8, AXI data width (multiple of 8)
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  2  per-requester command valid (bit i = requester i)
- req_write  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_WIDTH  requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  2*DATA_WIDTH  requester i write data at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  2  command accepted when valid & ready
- rsp_valid  out  2  one-cycle completion pulse to the owning requester
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid (0 for writes)
- rsp_resp  out  2  captured BRESP/RRESP, valid with rsp_valid
- m_axi_awaddr out ADDR_WIDTH; m_axi_awvalid out 1; m_axi_awready in 1
- m_axi_wdata out DATA_WIDTH; m_axi_wstrb out DATA_WIDTH/8, all ones; m_axi_wvalid out 1; m_axi_wready in 1
- m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1
- m_axi_araddr out ADDR_WIDTH; m_axi_arvalid out 1; m_axi_arready in 1
- m_axi_rdata in DATA_WIDTH; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1

## Operation
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE: grant g is chosen combinationally from req_valid.
  - If only one bit is set, that requester gets g.
  - If both are set, g = the requester not equal to last_grant.
  - req_ready[g] = 1 only in IDLE; req_ready is 0 in all other states.
- On acceptance:
  - Latch write, addr and wdata.
  - Set owner = g and last_grant = g.
  - Go to WRITE if the command is a write, otherwise READ.
- WRITE:
  - awvalid and wvalid both assert on entry.
  - Each one drops independently the cycle after its own handshake (awvalid&awready, wvalid&wready).
  - Once both handshakes are done, even in the same cycle, go to WRESP.
- WRESP: bready = 1. On bvalid, capture bresp, clear rdata_q to 0, go to RESP.
- READ: arvalid = 1 until arready, then go to RDATA.
- RDATA: rready = 1. On rvalid, capture rdata and rresp, go to RESP.
- RESP:
  - rsp_valid[owner] = 1 for exactly one cycle.
  - rsp_rdata and rsp_resp are held from capture until the next capture.
  - Next state is IDLE.
- There is no response backpressure; requesters must sample rsp_valid.
- Requester fields must stay stable while req_valid is high and unaccepted. Dropping req_valid before ready is legal and issues nothing.
- AXI valids never drop before their handshake, per AXI4-Lite.
- Addresses pass through unmodified; there is no address decode or error generation.
- Reset values:
  - State is IDLE and last_grant = 1, so requester 0 wins the first tie.
  - All m_axi_*valid, bready and rready are 0.
  - awaddr, araddr and wdata are 0.
  - req_ready and rsp_valid are 0.
  - rsp_rdata and rsp_resp are 0.
- Reset mid-operation: the next edge forces reset values. The in-flight transaction is abandoned with no rsp_valid, and the slave is reset by the same rst_n.

## Timing
- req_ready is combinational from state and req_valid. All other outputs are registered.
- Zero-wait slave (awready, wready, arready tied high; bvalid/rvalid one cycle after the address phase):
  - Write: accept at T0, awvalid/wvalid at T1, bvalid at T2, rsp_valid at T3.
  - Read: accept at T0, arvalid at T1, rvalid at T2, rsp_valid at T3.
  - Issue rate is one command per 4 cycles. The next acceptance can occur at T4, the cycle after RESP.
- A requester is never starved: with both continuously valid, grants alternate 0,1,0,1.
- AW and W completing in different cycles: WRESP is entered the cycle after the later handshake.

## Structure
- Shared package axi4lite_pkg holds:
  - The state enum.
  - The response codes OKAY=2'b00 and SLVERR=2'b10.
  - NUM_REQ = 2.
- Sub-module axi4lite_rr_grant: takes req_valid[1:0] and last_grant, produces grant index and grant_valid (pure combinational round-robin). The FSM and datapath stay in axi4lite_arbiter.

## Test plan
- Single write: req0 write, addr 2, data 0xA5, zero-wait slave.
  - awaddr=2 and wdata=0xA5 with wstrb=1 at T1.
  - rsp_valid=2'b01 at T3, rsp_resp=0, rsp_rdata=0.
- Read-back: after the write above, req1 reads addr 2 -> rsp_valid=2'b10, rsp_rdata=0xA5, rsp_resp=0.
- Contention: both requesters valid in IDLE after reset, held for 4 commands -> acceptance order 0,1,0,1, with each rsp_valid going to the matching bit.
- Split handshake: awready delayed 3 cycles, wready immediate.
  - wvalid drops after 1 cycle; awvalid is held for 3 cycles.
  - bready rises the cycle after the AW handshake; rsp_valid follows bvalid by 1 cycle.
- Error response: slave returns rresp=2'b10 on a read -> rsp_resp=2'b10 with rsp_valid; the next command proceeds normally.
- Reset mid-write: rst_n low during WRESP for 1 cycle.
  - All outputs return to reset values on the next edge, with no rsp_valid.
  - First post-reset tie is granted to requester 0.
